// File: rtl/irq_gateway.sv
// irq_gateway: conditions raw interrupt lines (sync, glitch filter, polarity,
// level/edge latching) into clean requests for the interrupt controller.
// Register map on addr[3:2]: 0 MODE, 1 POLARITY, 2 PENDING (W1C), 3 FILTER.

package xt_bus_pkg;
  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
  } hb_slave_t;

  typedef struct packed {
    logic wen;
    logic ren;
  } sel_t;
endpackage

module irq_gateway
  import xt_bus_pkg::*;
#(
  parameter int INT_NUM     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               hb_clk,
  input  logic               rst_sync,
  input  hb_slave_t          xt_hb,
  input  sel_t               sel,
  output logic [31:0]        rdata,
  input  logic [INT_NUM-1:0] irq_in,
  output logic [INT_NUM-1:0] irq_source
);

  localparam logic [1:0] A_MODE = 2'd0;
  localparam logic [1:0] A_POL  = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_FILT = 2'd3;

  logic [INT_NUM-1:0]                  r_mode, r_pol, r_pend, r_prev, r_filt;
  logic [3:0]                          r_filter;
  logic [SYNC_STAGES-1:0][INT_NUM-1:0] r_sync;
  logic [INT_NUM-1:0][3:0]             r_cnt;
  logic [31:0]                         r_rdata;

  logic               w_wr_mode, w_wr_pol, w_wr_pend, w_wr_filt;
  logic [INT_NUM-1:0] w_wdata, w_s, w_act, w_set, w_w1c, w_mchg;
  logic [31:0]        w_rd;
  logic               w_unused;

  // Only addr[3:2] and the low wdata bits matter; the rest is bus baggage.
  assign w_unused  = ^xt_hb;

  assign w_wdata   = xt_hb.wdata[INT_NUM-1:0];
  assign w_wr_mode = sel.wen && (xt_hb.waddr[3:2] == A_MODE);
  assign w_wr_pol  = sel.wen && (xt_hb.waddr[3:2] == A_POL);
  assign w_wr_pend = sel.wen && (xt_hb.waddr[3:2] == A_PEND);
  assign w_wr_filt = sel.wen && (xt_hb.waddr[3:2] == A_FILT);

  assign w_s   = r_sync[SYNC_STAGES-1];
  assign w_act = r_filt ^ r_pol;
  // Rising edge of the active sense, only meaningful for edge-mode sources.
  assign w_set = r_mode & w_act & ~r_prev;
  // W1C only touches edge latches; level bits have no latch to clear.
  assign w_w1c = w_wr_pend ? (w_wdata & r_mode) : '0;
  // Switching a source's mode discards whatever its latch held.
  assign w_mchg = w_wr_mode ? (w_wdata ^ r_mode) : '0;

  assign irq_source = (r_mode & r_pend) | (~r_mode & w_act);
  assign rdata      = r_rdata;

  // Control registers: MODE / POLARITY / FILTER written from the bus.
  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      r_mode   <= '0;
      r_pol    <= '0;
      r_filter <= '0;
    end else begin
      if (w_wr_mode) r_mode   <= w_wdata;
      if (w_wr_pol)  r_pol    <= w_wdata;
      if (w_wr_filt) r_filter <= xt_hb.wdata[3:0];
    end
  end

  // Synchronizer chains: one flop column per stage, all sources in parallel.
  always_ff @(posedge hb_clk) begin
    if (rst_sync) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
  end

  // Glitch filter: a change must hold FILTER+1 cycles; any revert restarts it.
  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < INT_NUM; i++) begin
        if (w_s[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == r_filter) begin
          r_filt[i] <= w_s[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Edge latches: set beats W1C, a mode change beats both.
  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= w_act;
      r_pend <= ((r_pend & ~w_w1c) | w_set) & ~w_mchg;
    end
  end

  // Read mux: addressed register, zero-extended to 32 bits.
  always_comb begin
    w_rd = '0;
    case (xt_hb.raddr[3:2])
      A_MODE:  w_rd[INT_NUM-1:0] = r_mode;
      A_POL:   w_rd[INT_NUM-1:0] = r_pol;
      A_PEND:  w_rd[INT_NUM-1:0] = irq_source;
      default: w_rd[3:0]         = r_filter;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge hb_clk) begin
    if (rst_sync)     r_rdata <= '0;
    else if (sel.ren) r_rdata <= w_rd;
  end

endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 SHALL have parameter INT_NUM, default 32, number of interrupt sources (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per source (>=2).
REQ-003 SHALL have port hb_clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_sync, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port xt_hb, input, hb_slave_t (XT_BUS): bus slave fields; uses waddr[3:2], raddr[3:2] and wdata.
REQ-006 SHALL have port sel, input, sel_t (XT_BUS): wen/ren strobes for this block.
REQ-007 SHALL have port rdata, output, 32 bits: registered read data.
REQ-008 SHALL have port irq_in, input, INT_NUM bits: raw, possibly asynchronous, peripheral/pin interrupt lines.
REQ-009 SHALL have port irq_source, output, INT_NUM bits: conditioned requests to the external interrupt controller's irq_source input.

Function
REQ-010 SHALL implement register map on addr[3:2]: 0 MODE (bit=1 edge, 0 level); 1 POLARITY (bit=1 active-low/falling); 2 PENDING; 3 FILTER[3:0].
REQ-011 SHALL write MODE/POLARITY/FILTER from wdata on sel.wen, next edge; bits >= INT_NUM and FILTER bits above 3 ignored.
REQ-012 SHALL treat a PENDING write as write-1-to-clear on edge-mode latches only; level-mode bits unaffected.
REQ-013 SHALL, on sel.ren, load rdata one cycle later with the addressed register (PENDING reads current irq_source, FILTER zero-extended, unused bits 0); rdata holds otherwise.
REQ-014 SHALL pass each irq_in bit through a SYNC_STAGES flop chain, giving s[i].
REQ-015 SHALL filter per source: filt[i] and 4-bit cnt[i]; if s==filt: cnt<=0; else if cnt==FILTER: filt<=s, cnt<=0; else cnt<=cnt+1 -- a change must persist FILTER+1 consecutive cycles.
REQ-016 SHALL compute act[i] = filt[i] XOR POLARITY[i] and register prev_act[i] <= act[i] every cycle.
REQ-017 SHALL set edge_pend[i] when MODE[i]=1 and act[i]=1 and prev_act[i]=0.
REQ-018 SHALL give set priority over a simultaneous W1C clear of the same bit.
REQ-019 SHALL drive irq_source[i] = MODE[i] ? edge_pend[i] : act[i] (no further register).
REQ-020 SHALL clear edge_pend[i] on any MODE write changing MODE[i].
REQ-021 SHALL treat a POLARITY change that flips act as a genuine edge (may latch); software clears.
REQ-022 SHALL give latency with SYNC_STAGES=2, FILTER=0, irq_in stable before edge 1: level irq_source high after edge 3; edge latch high after edge 4.
REQ-023 SHALL reset cnt when the input reverts mid-filter; no partial count carries over.

Reset
REQ-024 SHALL, on rst_sync, clear MODE, POLARITY, FILTER, sync chains, filt, cnt, prev_act, edge_pend, rdata to 0; irq_source=0 the cycle after reset.
REQ-025 SHALL make reset mid-filter or with latches pending discard all state; no edge latched on the first post-reset cycle unless act rises afterwards.

Verification
REQ-026 SHALL verify: level mode, FILTER=0, irq_in[0] 0->1 -> irq_source[0]=1 after 3rd edge, drops 3 edges after irq_in falls.
REQ-027 SHALL verify: MODE[5]=1, 2-cycle pulse on irq_in[5] -> irq_source[5]=1 after edge 4 and stays; PENDING write 0x20 -> 0 next cycle.
REQ-028 SHALL verify: FILTER=3, 3-cycle glitch on irq_in[1] -> no change; 4-cycle pulse -> filt flips.
REQ-029 SHALL verify: POLARITY[2]=1, edge mode, irq_in[2] 1->0 -> edge latched; 0->1 -> none.
REQ-030 SHALL verify: edge set and W1C same cycle -> bit stays 1; rst_sync mid-pending -> irq_source=0, rdata=0, PENDING reads 0.
